instr_fetch_queue: RTL and testbench

Parametrised instruction prefetch queue between the fetch controller (instruction cache side) and the decoder.
- Generates sequential fetch PCs, tracks outstanding fetch requests with credits and buffers returned instructions with their PCs in a DEPTH-entry circular FIFO.
- Presents the oldest entry to the decoder with a valid/ready handshake.
- On a ROB redirect it flushes the FIFO, discards in-flight responses by count and restarts fetch at the new PC.

---
 rtl/instr_fetch_queue.sv | 111 +++++++++++
 tb/tb_instr_fetch_queue.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue: sequential fetch PC generation, credit-tracked requests,
// FWFT FIFO toward the decoder, redirect flush. Optional same-cycle bypass under IFQ_BYPASS_EN.
module instr_fetch_queue #(
  parameter int DEPTH     = 16,
  parameter int PTR_W     = 4,
  parameter int PC_W      = 32,
  parameter int INSTR_W   = 32,
  parameter int MAX_OUTST = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               fetch_req_valid,
  output logic [PC_W-1:0]    fetch_req_pc,
  input  logic               fetch_req_ready,
  input  logic               fetch_rsp_valid,
  input  logic [INSTR_W-1:0] fetch_rsp_instr,
  output logic               dc_valid,
  output logic [INSTR_W-1:0] dc_instr,
  output logic [PC_W-1:0]    dc_pc,
  input  logic               dc_ready,
  output logic [PTR_W:0]     count
);

  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int CW = PTR_W + 1;

  logic [PC_W-1:0]    mem_pc    [DEPTH];
  logic [INSTR_W-1:0] mem_instr [DEPTH];

  logic [PTR_W-1:0] head_reg, tail_reg;
  logic [CW-1:0]    count_reg;
  logic [PC_W-1:0]  req_pc_reg, rsp_pc_reg;
  logic [OW-1:0]    outst_reg, drop_reg;

  logic [31:0] occ;
  logic        req_fire, keep, byp_valid, byp_take, wr_en, rd_en, stored_valid;

  always_comb begin
    occ             = 32'(count_reg) + 32'(outst_reg);
    fetch_req_valid = !redirect_valid && (32'(outst_reg) < 32'(MAX_OUTST)) && (occ < 32'(DEPTH));
    fetch_req_pc    = req_pc_reg;
    req_fire        = fetch_req_valid && fetch_req_ready;
    // A response survives only when no discards are pending and no redirect is flushing it.
    keep            = fetch_rsp_valid && (drop_reg == '0) && !redirect_valid;
`ifdef IFQ_BYPASS_EN
    byp_valid       = keep && (count_reg == '0);
`else
    byp_valid       = 1'b0;
`endif
    byp_take        = byp_valid && dc_ready;
    wr_en           = keep && !byp_take;
    stored_valid    = (count_reg != '0);
    rd_en           = stored_valid && dc_ready && !redirect_valid;
    dc_valid        = stored_valid || byp_valid;
    dc_pc           = '0;
    dc_instr        = '0;
    if (stored_valid) begin
      dc_pc    = mem_pc[head_reg];
      dc_instr = mem_instr[head_reg];
    end else if (byp_valid) begin
      dc_pc    = rsp_pc_reg;
      dc_instr = fetch_rsp_instr;
    end
    count = count_reg;
  end

  // Storage carries no reset; dc_pc/dc_instr are gated to zero while empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_pc[tail_reg]    <= rsp_pc_reg;
      mem_instr[tail_reg] <= fetch_rsp_instr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg   <= '0;
      tail_reg   <= '0;
      count_reg  <= '0;
      req_pc_reg <= RESET_PC;
      rsp_pc_reg <= RESET_PC;
      outst_reg  <= '0;
      drop_reg   <= '0;
    end else if (redirect_valid) begin
      head_reg   <= '0;
      tail_reg   <= '0;
      count_reg  <= '0;
      req_pc_reg <= redirect_pc;
      rsp_pc_reg <= redirect_pc;
      drop_reg   <= drop_reg + outst_reg - OW'(fetch_rsp_valid);
      outst_reg  <= outst_reg - OW'(fetch_rsp_valid);
    end else begin
      outst_reg <= outst_reg + OW'(req_fire) - OW'(fetch_rsp_valid);
      if (fetch_rsp_valid && (drop_reg != '0))
        drop_reg <= drop_reg - OW'(1);
      if (req_fire)
        req_pc_reg <= req_pc_reg + PC_W'(4);
      if (keep)
        rsp_pc_reg <= rsp_pc_reg + PC_W'(4);
      if (wr_en)
        tail_reg <= tail_reg + PTR_W'(1);
      if (rd_en)
        head_reg <= head_reg + PTR_W'(1);
      count_reg <= count_reg + CW'(wr_en) - CW'(rd_en);
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: a fetch-controller model answers requests one
// cycle later, expected decoder entries are queued at response time and checked by a monitor.
module tb_instr_fetch_queue;
  localparam int DEPTH = 16;
  localparam int MAX_OUTST = 4;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fetch_req_valid;
  logic [31:0] fetch_req_pc;
  logic        fetch_req_ready = 1'b0;
  logic        fetch_rsp_valid = 1'b0;
  logic [31:0] fetch_rsp_instr = '0;
  logic        dc_valid;
  logic [31:0] dc_instr;
  logic [31:0] dc_pc;
  logic        dc_ready = 1'b0;
  logic [4:0]  count;

  instr_fetch_queue dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_req_valid(fetch_req_valid), .fetch_req_pc(fetch_req_pc),
    .fetch_req_ready(fetch_req_ready),
    .fetch_rsp_valid(fetch_rsp_valid), .fetch_rsp_instr(fetch_rsp_instr),
    .dc_valid(dc_valid), .dc_instr(dc_instr), .dc_pc(dc_pc), .dc_ready(dc_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] pc; logic drop; } infl_t;
  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;

  infl_t       inflight[$];
  ent_t        exp_q[$];
  logic [31:0] req_pc_m = '0;
  logic        rsp_kept = 1'b0;
  int          checks = 0;
  int          failures = 0;
  bit          k_req_ready = 0, k_rsp_en = 0, k_dc_ready = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'h00A00093 ^ ((pc - 32'h20) << 7);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock cycle: apply knobs, let the controller model answer the oldest request.
  task automatic cycle(input bit redir, input logic [31:0] rpc);
    infl_t e;
    @(posedge clk);
    #1;
    fetch_req_ready = k_req_ready;
    dc_ready        = k_dc_ready;
    redirect_valid  = redir;
    redirect_pc     = rpc;
    fetch_rsp_valid = 1'b0;
    rsp_kept        = 1'b0;
    if (k_rsp_en && inflight.size() > 0) begin
      e = inflight.pop_front();
      fetch_rsp_valid = 1'b1;
      fetch_rsp_instr = instr_of(e.pc);
      if (!e.drop && !redir) begin
        rsp_kept = 1'b1;
        exp_q.push_back({e.pc, instr_of(e.pc)});
      end
    end
    if (redir) begin
      exp_q.delete();
      foreach (inflight[i]) inflight[i].drop = 1'b1;
      req_pc_m = rpc;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    fetch_rsp_valid = 1'b0;
    fetch_req_ready = 1'b0;
    dc_ready = 1'b0;
    rsp_kept = 1'b0;
    k_req_ready = 0; k_rsp_en = 0; k_dc_ready = 0;
    inflight.delete();
    exp_q.delete();
    req_pc_m = '0;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_dc_valid", 32'(dc_valid), 32'd0);
    check("rst_dc_pc", dc_pc, 32'd0);
    check("rst_dc_instr", dc_instr, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_req_valid", 32'(fetch_req_valid), 32'd1);
    check("rst_req_pc", fetch_req_pc, 32'd0);
  endtask

  // Monitor: model counts, request PCs and decoder pops, all sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      automatic int exp_count = exp_q.size() - (rsp_kept ? 1 : 0);
      automatic int exp_outst = inflight.size() + (fetch_rsp_valid ? 1 : 0);
      automatic ent_t e;
      check("req_valid", 32'(fetch_req_valid),
            32'(!redirect_valid && exp_outst < MAX_OUTST && exp_count + exp_outst < DEPTH));
      if (!redirect_valid) begin
        check("count", 32'(count), 32'(exp_count));
        check("dc_valid", 32'(dc_valid), 32'((exp_count != 0) || (BYP && rsp_kept)));
      end
      if (fetch_req_valid && fetch_req_ready) begin
        check("req_pc", fetch_req_pc, req_pc_m);
        inflight.push_back({req_pc_m, 1'b0});
        req_pc_m = req_pc_m + 32'd4;
      end
      if (dc_valid && dc_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL dc_unexpected actual_pc=0x%0h required=none at %0t", dc_pc, $time);
        end else begin
          e = exp_q.pop_front();
          check("dc_pc", dc_pc, e.pc);
          check("dc_instr", dc_instr, e.instr);
        end
      end
    end
  end

  initial begin
    do_reset();

    // Streaming with one-cycle response latency.
    k_req_ready = 1; k_rsp_en = 1; k_dc_ready = 1;
    repeat (20) begin
      cycle(0, '0);
      #1 check("stream_count_le2", 32'(count <= 5'd2), 32'd1);
    end

    // Fill to the credit limit with the decoder stalled.
    k_dc_ready = 0;
    repeat (30) cycle(0, '0);
    #1;
    check("fill_count", 32'(count), 32'd16);
    check("fill_req_valid", 32'(fetch_req_valid), 32'd0);
    k_dc_ready = 1;
    repeat (20) cycle(0, '0);

    // Simultaneous write and read near full: count must hold.
    k_dc_ready = 0;
    repeat (30) cycle(0, '0);
    k_dc_ready = 1; k_rsp_en = 0;
    cycle(0, '0);
    k_dc_ready = 0;
    cycle(0, '0);
    k_dc_ready = 1; k_rsp_en = 1;
    cycle(0, '0);
    k_dc_ready = 0; k_rsp_en = 0; k_req_ready = 0;
    cycle(0, '0);
    #1 check("rw_count_hold", 32'(count), 32'd15);

    // Wrap-around with random decoder and controller stalls.
    k_req_ready = 1;
    repeat (80) begin
      k_dc_ready = ($urandom_range(0, 1) == 1);
      k_rsp_en   = ($urandom_range(0, 3) != 0);
      cycle(0, '0);
    end

    // Drain, then redirect with three requests in flight and a response in the same cycle.
    k_req_ready = 0; k_rsp_en = 1; k_dc_ready = 1;
    repeat (25) cycle(0, '0);
    k_req_ready = 1; k_rsp_en = 0;
    repeat (3) cycle(0, '0);
    k_rsp_en = 1;
    cycle(1, 32'h100);
    cycle(0, '0);
    #1;
    check("redir_req_pc", fetch_req_pc, 32'h100);
    check("redir_req_valid", 32'(fetch_req_valid), 32'd1);
    check("redir_dc_valid", 32'(dc_valid), 32'd0);
    repeat (20) cycle(0, '0);

`ifdef IFQ_BYPASS_EN
    k_req_ready = 0; k_rsp_en = 1; k_dc_ready = 1;
    repeat (10) cycle(0, '0);
    k_rsp_en = 0;
    cycle(1, 32'h20);
    k_req_ready = 1;
    cycle(0, '0);
    k_req_ready = 0; k_rsp_en = 1;
    cycle(0, '0);
    #1;
    check("byp_dc_valid", 32'(dc_valid), 32'd1);
    check("byp_dc_pc", dc_pc, 32'h20);
    check("byp_dc_instr", dc_instr, 32'h00A00093);
    check("byp_count", 32'(count), 32'd0);
    repeat (3) cycle(0, '0);
`endif

    // Reset in the middle of traffic, then resume streaming from RESET_PC.
    k_req_ready = 1; k_rsp_en = 1; k_dc_ready = 0;
    repeat (6) cycle(0, '0);
    do_reset();
    k_req_ready = 1; k_rsp_en = 1; k_dc_ready = 1;
    repeat (12) cycle(0, '0);
    k_req_ready = 0;
    repeat (6) cycle(0, '0);
    #1 check("end_count", 32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
